sc_core_oz_fetch: RTL and testbench

Instruction fetch stage for the sc_core_oz RV32I core. Holds the program counter, issues one request at a time to the instruction memory over a request/response handshake, and presents the fetched word with its PC and PC+4 to the decode/register-file stage. Redirects the PC on taken branches and jumps. Raises a sticky error and halts on a misaligned target.

---
 rtl/sc_core_oz_fetch.sv | 92 +++++++++
 tb/tb_sc_core_oz_fetch.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_core_oz_fetch.sv
// Instruction fetch stage for sc_core_oz: holds the PC, runs one imem request at a time,
// and presents the fetched word with Pc/PcPlus4 until decode accepts it.
module sc_core_oz_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReqReady,
  input  logic        ImemRspValid,
  input  logic [31:0] ImemRspData,
  input  logic        InstAccept,
  input  logic        NextPcSel,
  input  logic [31:0] NextPcTarget,
  output logic        InstValid,
  output logic [31:0] Instruction,
  output logic [31:0] Pc,
  output logic [31:0] PcPlus4,
  output logic [31:0] FetchCount,
  output logic        ErrMisaligned
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] fcnt_q;
  logic        err_q;

  // Modulo-2^32 increment; wrapping past the top of memory is legal.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:   if (ImemReqReady) state_nxt = S_WAIT;
      S_WAIT:  if (ImemRspValid) state_nxt = S_VALID;
      S_VALID: begin
        if (InstAccept) begin
          if (NextPcSel && misaligned(NextPcTarget)) state_nxt = S_HALT;
          else                                       state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_REQ;
      pc_q   <= RESET_PC;
      inst_q <= NOP;
      fcnt_q <= 32'd0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_WAIT && ImemRspValid) inst_q <= ImemRspData;
      if (state == S_VALID && InstAccept) begin
        fcnt_q <= fcnt_q + 32'd1;
        if (!NextPcSel)                    pc_q  <= pc_inc(pc_q);
        else if (!misaligned(NextPcTarget)) pc_q  <= NextPcTarget;
        else                               err_q <= 1'b1;
      end
    end
  end

  // All outputs come from registers or the state register only.
  assign ImemReq       = (state == S_REQ);
  assign ImemAddr      = pc_q;
  assign InstValid     = (state == S_VALID);
  assign Instruction   = inst_q;
  assign Pc            = pc_q;
  assign PcPlus4       = pc_inc(pc_q);
  assign FetchCount    = fcnt_q;
  assign ErrMisaligned = err_q;

endmodule

// File: tb/tb_sc_core_oz_fetch.sv
// Directed bench for sc_core_oz_fetch: expected {pc, word} pairs are queued when a
// request is accepted and popped when the fetch stage presents the instruction.
module tb_sc_core_oz_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemReqReady;
  logic        ImemRspValid;
  logic [31:0] ImemRspData;
  logic        InstAccept;
  logic        NextPcSel;
  logic [31:0] NextPcTarget;
  logic        InstValid;
  logic [31:0] Instruction;
  logic [31:0] Pc;
  logic [31:0] PcPlus4;
  logic [31:0] FetchCount;
  logic        ErrMisaligned;

  logic        w_req, w_ready, w_rspv, w_acc, w_sel, w_vld, w_err;
  logic [31:0] w_addr, w_rspd, w_tgt, w_inst, w_pc, w_pcp4, w_cnt;

  int nchecks = 0;
  int nerrors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } sb_t;
  sb_t sb[$];

  always #5 clk = ~clk;

  sc_core_oz_fetch u_dut (
    .clk(clk), .rst(rst),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemReqReady(ImemReqReady),
    .ImemRspValid(ImemRspValid), .ImemRspData(ImemRspData),
    .InstAccept(InstAccept), .NextPcSel(NextPcSel), .NextPcTarget(NextPcTarget),
    .InstValid(InstValid), .Instruction(Instruction), .Pc(Pc), .PcPlus4(PcPlus4),
    .FetchCount(FetchCount), .ErrMisaligned(ErrMisaligned)
  );

  sc_core_oz_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst),
    .ImemReq(w_req), .ImemAddr(w_addr), .ImemReqReady(w_ready),
    .ImemRspValid(w_rspv), .ImemRspData(w_rspd),
    .InstAccept(w_acc), .NextPcSel(w_sel), .NextPcTarget(w_tgt),
    .InstValid(w_vld), .Instruction(w_inst), .Pc(w_pc), .PcPlus4(w_pcp4),
    .FetchCount(w_cnt), .ErrMisaligned(w_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // One complete fetch starting in S_REQ: rdly cycles of backpressure, rspdly idle
  // cycles in S_WAIT, then the response, presentation check and acceptance.
  task automatic fetch_one(input int rdly, input int rspdly, input logic [31:0] word,
                           input logic [31:0] exp_pc, input bit hold_acc, input bit spur,
                           input bit sel, input logic [31:0] tgt);
    sb_t e;
    for (int i = 0; i < rdly; i++) begin
      ImemReqReady = 1'b0;
      ImemRspValid = spur;
      ImemRspData  = 32'hDEAD_BEEF;
      chk("req_hold", {31'd0, ImemReq}, 32'd1);
      chk("addr_hold", ImemAddr, exp_pc);
      step();
    end
    ImemRspValid = 1'b0;
    chk("req", {31'd0, ImemReq}, 32'd1);
    chk("addr", ImemAddr, exp_pc);
    chk("pcp4_req", PcPlus4, exp_pc + 32'd4);
    ImemReqReady = 1'b1;
    e.pc   = exp_pc;
    e.word = word;
    sb.push_back(e);
    step();
    ImemReqReady = 1'b0;
    for (int i = 0; i < rspdly; i++) begin
      chk("wait_req", {31'd0, ImemReq}, 32'd0);
      chk("wait_vld", {31'd0, InstValid}, 32'd0);
      step();
    end
    chk("wait_req", {31'd0, ImemReq}, 32'd0);
    ImemRspValid = 1'b1;
    ImemRspData  = word;
    step();
    ImemRspValid = 1'b0;
    ImemRspData  = 32'd0;
    chk("vld", {31'd0, InstValid}, 32'd1);
    if (sb.size() == 0) begin
      nchecks++;
      nerrors++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk("inst", Instruction, e.word);
      chk("pc", Pc, e.pc);
      chk("pcp4", PcPlus4, e.pc + 32'd4);
    end
    if (!hold_acc) InstAccept = 1'b1;
    NextPcSel    = sel;
    NextPcTarget = tgt;
    step();
    if (!hold_acc) InstAccept = 1'b0;
    NextPcSel = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ImemReqReady = 0; ImemRspValid = 0; ImemRspData = 0;
    InstAccept = 0; NextPcSel = 0; NextPcTarget = 0;
    w_ready = 0; w_rspv = 0; w_rspd = 0; w_acc = 0; w_sel = 0; w_tgt = 0;
    do_reset();

    chk("rst_pc", Pc, 32'h0);
    chk("rst_pcp4", PcPlus4, 32'h4);
    chk("rst_inst", Instruction, 32'h0000_0013);
    chk("rst_vld", {31'd0, InstValid}, 32'd0);
    chk("rst_req", {31'd0, ImemReq}, 32'd1);
    chk("rst_cnt", FetchCount, 32'd0);
    chk("rst_err", {31'd0, ErrMisaligned}, 32'd0);

    // PC wrap on the second instance
    chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap_pcp4", w_pcp4, 32'h0);
    w_ready = 1'b1; step(); w_ready = 1'b0;
    w_rspv = 1'b1; w_rspd = 32'h0000_0073; step(); w_rspv = 1'b0;
    chk("wrap_vld", {31'd0, w_vld}, 32'd1);
    chk("wrap_inst", w_inst, 32'h0000_0073);
    w_acc = 1'b1; step(); w_acc = 1'b0;
    chk("wrap_addr", w_addr, 32'h0);
    chk("wrap_req", {31'd0, w_req}, 32'd1);
    chk("wrap_err", {31'd0, w_err}, 32'd0);
    chk("wrap_cnt", w_cnt, 32'd1);

    // Sequential, zero-wait memory, InstAccept held high throughout
    InstAccept = 1'b1;
    fetch_one(0, 0, 32'h0010_0093, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    fetch_one(0, 0, 32'h0020_0113, 32'h4, 1'b1, 1'b0, 1'b0, 32'h0);
    fetch_one(0, 0, 32'h0030_0193, 32'h8, 1'b1, 1'b0, 1'b0, 32'h0);
    fetch_one(0, 0, 32'h0040_0213, 32'hC, 1'b1, 1'b0, 1'b0, 32'h0);
    InstAccept = 1'b0;
    chk("seq_cnt", FetchCount, 32'd4);
    chk("seq_addr", ImemAddr, 32'h10);

    // Backpressure, delayed response, then branch at 0x8 and spurious response at 0x100
    do_reset();
    fetch_one(5, 2, 32'hCAFE_0001, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    fetch_one(0, 1, 32'hCAFE_0002, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0);
    fetch_one(0, 0, 32'hCAFE_0003, 32'h8, 1'b0, 1'b0, 1'b1, 32'h100);
    chk("redir_addr", ImemAddr, 32'h100);
    chk("redir_pcp4", PcPlus4, 32'h104);
    chk("spur_inst_before", Instruction, 32'hCAFE_0003);
    fetch_one(2, 0, 32'hCAFE_0004, 32'h100, 1'b0, 1'b1, 1'b1, 32'h102);

    // Misaligned target: halted with sticky error regardless of inputs
    ImemReqReady = 1'b1; ImemRspValid = 1'b1; InstAccept = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("mis_err", {31'd0, ErrMisaligned}, 32'd1);
      chk("mis_req", {31'd0, ImemReq}, 32'd0);
      chk("mis_vld", {31'd0, InstValid}, 32'd0);
      chk("mis_cnt", FetchCount, 32'd4);
      chk("mis_pc", Pc, 32'h100);
      step();
    end
    ImemReqReady = 1'b0; ImemRspValid = 1'b0; InstAccept = 1'b0;

    // Reset while a response is outstanding
    do_reset();
    fetch_one(0, 0, 32'h1111_1111, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    ImemReqReady = 1'b1; step(); ImemReqReady = 1'b0;
    chk("mw_in_wait", {31'd0, ImemReq}, 32'd0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mw_pc", Pc, 32'h0);
    chk("mw_vld", {31'd0, InstValid}, 32'd0);
    chk("mw_req", {31'd0, ImemReq}, 32'd1);
    chk("mw_cnt", FetchCount, 32'd0);
    chk("mw_err", {31'd0, ErrMisaligned}, 32'd0);
    chk("mw_inst", Instruction, 32'h0000_0013);
    sb.delete();

    // Reset in the same cycle as InstAccept
    ImemReqReady = 1'b1; step(); ImemReqReady = 1'b0;
    ImemRspValid = 1'b1; ImemRspData = 32'h2222_2222; step(); ImemRspValid = 1'b0;
    chk("ra_vld", {31'd0, InstValid}, 32'd1);
    InstAccept = 1'b1; NextPcSel = 1'b1; NextPcTarget = 32'h40; rst = 1'b1;
    step();
    rst = 1'b0; InstAccept = 1'b0; NextPcSel = 1'b0;
    chk("ra_pc", Pc, 32'h0);
    chk("ra_cnt", FetchCount, 32'd0);
    chk("ra_req", {31'd0, ImemReq}, 32'd1);
    chk("ra_vld_after", {31'd0, InstValid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
